ws2811_frame_scheduler: RTL and testbench
=========================================

# ws2811_frame_scheduler

Frame-level sequencer for the WS2811 LED chain. It latches one colour from the RGB wave provider per frame and hands that colour to the bit serializer once per LED over a valid/ready handshake. It then holds the chain in latch/reset for the required low time and pulses the wave provider's `advance` input to step the animation. It sits between the wave provider (colour source) and the WS2811 serializer (line driver).

## Interface
- `NUM_LEDS`, default 50: pixels sent per frame; legal range 1..4095.
- `GAP_CYCLES`, default 2800: clock cycles `serial_reset` is held per frame (≥50 µs at 50 MHz); legal ≥2.
- `ADVANCE_PER_FRAME`, default 1000: `advance` cycles issued per frame; legal ≥1.
- `GRB_ORDER`, default 1: 1 means `pixel_data` = {g,r,b}; 0 means pass-through {r,g,b}.
- `clock`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: start or continue frames; sampled only in IDLE and at the end of ADVANCE.
- `rgb_in`, in, 24: {r,g,b} from the wave provider.
- `pixel_ready`, in, 1: the serializer accepts `pixel_data` this cycle.
- `pixel_valid`, out, 1: `pixel_data` is valid.
- `pixel_data`, out, 24: colour for the current LED.
- `serial_reset`, out, 1: tells the serializer to hold the line low (latch).
- `advance`, out, 1: one-cycle-per-step enable to the wave provider.
- `frame_done`, out, 1: single-cycle pulse at the end of each frame.
- `busy`, out, 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, LATCH, SEND, GAP, ADVANCE.
- **IDLE**
  - Outputs are at their reset values.
  - `enable`=1 moves to LATCH on the next cycle.
- **LATCH** (1 cycle)
  - `colour_q` ← `rgb_in`.
  - `led_cnt` ← 0.
  - Next state: SEND.
- **SEND**
  - `pixel_valid`=1.
  - `pixel_data` = reordered `colour_q`. It is stable while `valid` is high and `ready` is low.
  - A handshake (`valid`&`ready`) increments `led_cnt`.
  - A handshake when `led_cnt`==NUM_LEDS-1 moves to GAP, and `pixel_valid` drops the next cycle.
  - `pixel_valid` never drops without a handshake.
- **GAP**
  - `serial_reset`=1 for exactly GAP_CYCLES cycles.
  - `gap_cnt` counts 0..GAP_CYCLES-1.
  - Next state: ADVANCE.
- **ADVANCE**
  - `advance`=1 for exactly ADVANCE_PER_FRAME consecutive cycles.
  - On the last of those cycles, `frame_done`=1.
  - Then: `enable`=1 goes to LATCH (back-to-back frame); `enable`=0 goes to IDLE.
- Dropping `enable` mid-frame does not abort. The frame completes through ADVANCE.
- `rgb_in` changes during SEND are ignored. Every LED in a frame receives the same `colour_q`.
- Counter widths: `led_cnt` is 12 bits, `gap_cnt` is `$clog2(GAP_CYCLES)`, `adv_cnt` is `$clog2(ADVANCE_PER_FRAME+1)`.

## Timing
- Reset values:
  - state IDLE.
  - `pixel_valid`, `serial_reset`, `advance`, `frame_done`, `busy` = 0.
  - `pixel_data` = 0.
  - All counters 0.
- Reset asserted mid-frame returns to IDLE on the next edge.
  - All outputs are forced low immediately (registered).
  - A partially sent pixel is abandoned.
- Latency: `enable` rise in IDLE gives `pixel_valid` high 2 cycles later (IDLE→LATCH→SEND).
- Frame length = 2 + Σ(SEND cycles) + GAP_CYCLES + ADVANCE_PER_FRAME. With `pixel_ready` held high, SEND takes NUM_LEDS cycles.
- All outputs are registered. `pixel_ready` has no combinational path to any output.
- `serial_reset` and `pixel_valid` are never high in the same cycle.
- `advance` is never high outside ADVANCE.

## Structure
- Shared package `ws2811_pkg`:
  - state typedef `ws2811_sched_state_t`.
  - `WS2811_RGB_W`=24.
  - function `ws2811_reorder(rgb, grb_order)`.
- One sub-module, `ws2811_pulse_timer`:
  - Loadable down-counter with a `done` output.
  - Instanced twice: once for the GAP duration, once for the ADVANCE duration.
- Top-level holds the FSM, `led_cnt`, `colour_q` and the output registers.

## Test plan
1. **Basic frame.** NUM_LEDS=4, GAP=10, ADV=3, `ready`=1, `rgb_in`=24'hFF8000, `enable` pulsed 1 cycle.
   - Expect 4 handshakes with `pixel_data`=24'h80FF00 (GRB).
   - Then `serial_reset` high for exactly 10 cycles, then `advance` high for exactly 3 cycles, `frame_done` on the 3rd.
   - Then IDLE; total 19 cycles from LATCH.
2. **Backpressure.** `ready` toggles 1,0,0,1,…
   - `pixel_data` is held stable while stalled.
   - Exactly NUM_LEDS handshakes occur; `serial_reset` rises the cycle after the last handshake.
3. **Colour freeze.** `rgb_in` changes to 24'h0000FF mid-SEND.
   - All pixels in the current frame still carry the latched colour.
   - The next frame carries 24'h0000FF.
4. **Continuous run.** `enable` held high.
   - LATCH follows the last `advance` cycle immediately.
   - `frame_done` period equals the formula value (19 cycles in config 1).
5. **Reset mid-frame.** Assert `reset` during GAP cycle 5.
   - Next cycle: all outputs 0, state IDLE.
   - After release with `enable`=1, a clean frame starts at `led_cnt`=0.
6. **Edge config.** NUM_LEDS=1, `GRB_ORDER`=0, `rgb_in`=24'h123456.
   - Exactly one handshake with 24'h123456.
   - `enable` dropped during SEND still completes GAP and ADVANCE, then IDLE.

Source files
------------

// File: rtl/ws2811_pkg.sv
// Shared types and helpers for the WS2811 frame scheduler.
// Covers the FSM state type, the colour width and the GRB/RGB byte reorder.
package ws2811_pkg;

    localparam int unsigned WS2811_RGB_W = 24;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSend,
        StGap,
        StAdvance
    } ws2811_sched_state_t;

    // rgb is {r,g,b}; WS2811 pixels expect {g,r,b} on the wire
    function automatic logic [WS2811_RGB_W-1:0] ws2811_reorder(
        input logic [WS2811_RGB_W-1:0] rgb,
        input logic                    grb_order
    );
        if (grb_order) begin
            return {rgb[15:8], rgb[23:16], rgb[7:0]};
        end
        return rgb;
    endfunction

endpackage

// File: rtl/ws2811_pulse_timer.sv
// Loadable down-counter: load sets the count, it then decrements to zero and holds.
// done is high whenever the count is zero.
module ws2811_pulse_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/ws2811_frame_scheduler.sv
// Frame sequencer for a WS2811 chain: latch one colour, send it to every LED,
// hold the line in latch for the gap, then step the wave provider.
module ws2811_frame_scheduler
    import ws2811_pkg::*;
#(
    parameter int unsigned NUM_LEDS          = 50,
    parameter int unsigned GAP_CYCLES        = 2800,
    parameter int unsigned ADVANCE_PER_FRAME = 1000,
    parameter bit          GRB_ORDER         = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [WS2811_RGB_W-1:0] rgb_in,
    input  logic                    pixel_ready,
    output logic                    pixel_valid,
    output logic [WS2811_RGB_W-1:0] pixel_data,
    output logic                    serial_reset,
    output logic                    advance,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int unsigned GapW = $clog2(GAP_CYCLES);
    localparam int unsigned AdvW = $clog2(ADVANCE_PER_FRAME + 1);

    localparam logic [11:0]     LastLed = 12'(NUM_LEDS - 1);
    localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES - 1);
    // The advance timer runs one cycle ahead so frame_done can be registered.
    localparam logic [AdvW-1:0] AdvLoad =
        AdvW'((ADVANCE_PER_FRAME >= 2) ? (ADVANCE_PER_FRAME - 2) : 0);

    ws2811_sched_state_t     state_q;
    logic [11:0]             led_cnt_q;
    logic [WS2811_RGB_W-1:0] colour_q;
    logic [WS2811_RGB_W-1:0] pixel_data_q;
    logic                    pixel_valid_q;
    logic                    serial_reset_q;
    logic                    advance_q;
    logic                    frame_done_q;
    logic                    busy_q;

    logic last_handshake;
    logic gap_load;
    logic gap_done;
    logic adv_load;
    logic adv_done;

    always_comb begin
        last_handshake = (state_q == StSend) && pixel_ready && (led_cnt_q == LastLed);
        gap_load       = last_handshake;
        adv_load       = (state_q == StGap) && gap_done && !serial_reset_q;
    end

    ws2811_pulse_timer #(
        .WIDTH (GapW)
    ) u_gap_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GapLoad),
        .done       (gap_done)
    );

    ws2811_pulse_timer #(
        .WIDTH (AdvW)
    ) u_adv_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (adv_load),
        .load_value (AdvLoad),
        .done       (adv_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            led_cnt_q      <= '0;
            colour_q       <= '0;
            pixel_data_q   <= '0;
            pixel_valid_q  <= 1'b0;
            serial_reset_q <= 1'b0;
            advance_q      <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StLatch;
                        busy_q  <= 1'b1;
                    end
                end
                StLatch: begin
                    colour_q      <= rgb_in;
                    pixel_data_q  <= ws2811_reorder(rgb_in, GRB_ORDER);
                    led_cnt_q     <= '0;
                    pixel_valid_q <= 1'b1;
                    state_q       <= StSend;
                end
                StSend: begin
                    if (pixel_ready) begin
                        led_cnt_q <= led_cnt_q + 12'd1;
                        if (last_handshake) begin
                            pixel_valid_q  <= 1'b0;
                            pixel_data_q   <= '0;
                            serial_reset_q <= 1'b1;
                            state_q        <= StGap;
                        end else begin
                            pixel_data_q <= ws2811_reorder(colour_q, GRB_ORDER);
                        end
                    end
                end
                StGap: begin
                    // One released-line cycle after the latch window before advancing.
                    if (gap_done) begin
                        if (serial_reset_q) begin
                            serial_reset_q <= 1'b0;
                        end else begin
                            state_q      <= StAdvance;
                            advance_q    <= 1'b1;
                            frame_done_q <= (ADVANCE_PER_FRAME == 1);
                        end
                    end
                end
                StAdvance: begin
                    if (frame_done_q) begin
                        advance_q    <= 1'b0;
                        frame_done_q <= 1'b0;
                        if (enable) begin
                            state_q <= StLatch;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else if (adv_done) begin
                        frame_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign pixel_valid  = pixel_valid_q;
    assign pixel_data   = pixel_data_q;
    assign serial_reset = serial_reset_q;
    assign advance      = advance_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ws2811_frame_scheduler.sv
// Directed bench for ws2811_frame_scheduler: two instances (4 LED GRB, 1 LED RGB)
// driven through a linear sequence with hand-computed per-cycle expectations.
module tb_ws2811_frame_scheduler;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_a, enable_a, ready_a;
    logic [23:0] rgb_a, data_a;
    logic        valid_a, sr_a, adv_a, done_a, busy_a;

    logic        reset_b, enable_b, ready_b;
    logic [23:0] rgb_b, data_b;
    logic        valid_b, sr_b, adv_b, done_b, busy_b;

    int checks = 0;
    int errors = 0;

    ws2811_frame_scheduler #(
        .NUM_LEDS          (4),
        .GAP_CYCLES        (10),
        .ADVANCE_PER_FRAME (3),
        .GRB_ORDER         (1'b1)
    ) dut_a (
        .clock        (clock),
        .reset        (reset_a),
        .enable       (enable_a),
        .rgb_in       (rgb_a),
        .pixel_ready  (ready_a),
        .pixel_valid  (valid_a),
        .pixel_data   (data_a),
        .serial_reset (sr_a),
        .advance      (adv_a),
        .frame_done   (done_a),
        .busy         (busy_a)
    );

    ws2811_frame_scheduler #(
        .NUM_LEDS          (1),
        .GAP_CYCLES        (4),
        .ADVANCE_PER_FRAME (2),
        .GRB_ORDER         (1'b0)
    ) dut_b (
        .clock        (clock),
        .reset        (reset_b),
        .enable       (enable_b),
        .rgb_in       (rgb_b),
        .pixel_ready  (ready_b),
        .pixel_valid  (valid_b),
        .pixel_data   (data_b),
        .serial_reset (sr_b),
        .advance      (adv_b),
        .frame_done   (done_b),
        .busy         (busy_b)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // k counts cycles from the LATCH cycle (k=0) with pixel_ready held high:
    // SEND 1..n, serial_reset n+1..n+gap, one released cycle, advance, then idle.
    task automatic check_sched(input string tag, input int k, input int n, input int gap,
                               input int adv, input logic [23:0] exp_data,
                               input logic v, input logic [23:0] d, input logic sr,
                               input logic ad, input logic fd, input logic bz);
        logic e_valid, e_sr, e_adv, e_done, e_busy;
        int   last;
        last    = n + gap + 1 + adv;
        e_valid = (k >= 1) && (k <= n);
        e_sr    = (k >= n + 1) && (k <= n + gap);
        e_adv   = (k >= n + gap + 2) && (k <= last);
        e_done  = (k == last);
        e_busy  = (k <= last);
        check_bit($sformatf("%s k=%0d valid", tag, k), v, e_valid);
        check_word($sformatf("%s k=%0d data", tag, k), 32'(d), e_valid ? 32'(exp_data) : 32'h0);
        check_bit($sformatf("%s k=%0d serial_reset", tag, k), sr, e_sr);
        check_bit($sformatf("%s k=%0d advance", tag, k), ad, e_adv);
        check_bit($sformatf("%s k=%0d frame_done", tag, k), fd, e_done);
        check_bit($sformatf("%s k=%0d busy", tag, k), bz, e_busy);
    endtask

    task automatic wait_idle_a(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (!busy_a) break;
            step();
        end
        check_bit({tag, " returns idle"}, busy_a, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  pat;
        int          hs;
        int          p;
        int          n;
        logic        pv;

        reset_a  = 1'b1;
        reset_b  = 1'b1;
        enable_a = 1'b0;
        enable_b = 1'b0;
        ready_a  = 1'b1;
        ready_b  = 1'b1;
        rgb_a    = 24'hFF8000;
        rgb_b    = 24'h123456;
        step();
        step();

        // Reset state
        check_bit("reset valid", valid_a, 1'b0);
        check_word("reset data", 32'(data_a), 32'h0);
        check_bit("reset serial_reset", sr_a, 1'b0);
        check_bit("reset advance", adv_a, 1'b0);
        check_bit("reset frame_done", done_a, 1'b0);
        check_bit("reset busy", busy_a, 1'b0);
        check_bit("reset busy b", busy_b, 1'b0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        step();
        check_bit("idle without enable", busy_a, 1'b0);

        // 1: basic frame, enable pulsed for one cycle
        enable_a = 1'b1;
        step();
        enable_a = 1'b0;
        for (int k = 0; k <= 19; k++) begin
            check_sched("t1", k, 4, 10, 3, 24'h80FF00,
                        valid_a, data_a, sr_a, adv_a, done_a, busy_a);
            step();
        end

        // 2: backpressure with ready pattern 1,0,0,1,...
        pat      = 4'b1001;
        enable_a = 1'b1;
        step();
        enable_a = 1'b0;
        hs = 0;
        p  = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (hs == 4) break;
            ready_a = pat[p % 4];
            p++;
            pv = valid_a;
            step();
            if (pv && ready_a) begin
                hs++;
                if (hs == 4) begin
                    check_bit("t2 serial_reset after last handshake", sr_a, 1'b1);
                    check_bit("t2 valid drops after last handshake", valid_a, 1'b0);
                end
            end else if (pv) begin
                check_bit("t2 stall valid held", valid_a, 1'b1);
                check_word("t2 stall data held", 32'(data_a), 32'h80FF00);
            end
        end
        check_word("t2 handshake count", hs, 4);
        ready_a = 1'b1;
        wait_idle_a("t2");

        // 3: rgb_in changes mid-SEND are ignored until the next frame
        enable_a = 1'b1;
        step();
        enable_a = 1'b0;
        step();
        rgb_a = 24'h0000FF;
        for (int i = 0; i < 4; i++) begin
            check_bit($sformatf("t3 pixel %0d valid", i), valid_a, 1'b1);
            check_word($sformatf("t3 pixel %0d data", i), 32'(data_a), 32'h80FF00);
            step();
        end
        check_bit("t3 valid ends", valid_a, 1'b0);
        wait_idle_a("t3");
        enable_a = 1'b1;
        step();
        enable_a = 1'b0;
        step();
        check_bit("t3 next frame valid", valid_a, 1'b1);
        check_word("t3 next frame data", 32'(data_a), 32'h0000FF);
        wait_idle_a("t3 next");

        // 4: continuous run with enable held high
        enable_a = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (done_a) break;
            step();
        end
        check_bit("t4 first frame_done", done_a, 1'b1);
        step();
        check_bit("t4 latch advance low", adv_a, 1'b0);
        check_bit("t4 latch busy", busy_a, 1'b1);
        check_bit("t4 latch valid low", valid_a, 1'b0);
        step();
        check_bit("t4 send follows latch", valid_a, 1'b1);
        n = 2;
        for (int i = 0; i < 60; i++) begin
            step();
            n++;
            if (done_a) break;
        end
        check_word("t4 frame_done period", n, 19);
        enable_a = 1'b0;
        step();
        wait_idle_a("t4");

        // 5: reset during GAP cycle 5, then a clean frame
        rgb_a    = 24'h00FF00;
        enable_a = 1'b1;
        step();
        enable_a = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check_bit("t5 in gap before reset", sr_a, 1'b1);
        reset_a = 1'b1;
        step();
        check_bit("t5 reset valid", valid_a, 1'b0);
        check_word("t5 reset data", 32'(data_a), 32'h0);
        check_bit("t5 reset serial_reset", sr_a, 1'b0);
        check_bit("t5 reset advance", adv_a, 1'b0);
        check_bit("t5 reset frame_done", done_a, 1'b0);
        check_bit("t5 reset busy", busy_a, 1'b0);
        reset_a  = 1'b0;
        enable_a = 1'b1;
        step();
        enable_a = 1'b0;
        for (int k = 0; k <= 19; k++) begin
            check_sched("t5", k, 4, 10, 3, 24'hFF0000,
                        valid_a, data_a, sr_a, adv_a, done_a, busy_a);
            step();
        end

        // 6: one LED, RGB pass-through, enable dropped during SEND
        enable_b = 1'b1;
        step();
        for (int k = 0; k <= 10; k++) begin
            check_sched("t6", k, 1, 4, 2, 24'h123456,
                        valid_b, data_b, sr_b, adv_b, done_b, busy_b);
            if (k == 1) enable_b = 1'b0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
